// File: rtl/ref_clk_conditioner.sv
// ---------------------------------------------------------------------------
// ref_clk_conditioner
//
// Turns an asynchronous external reference clock into the single-cycle
// referenceClkEn strobe used by the digital PLL phase comparator. The input
// goes through a two-flop synchroniser and a deglitch filter. Its rising
// edges are then divided by a programmable ratio. The strobe-to-strobe
// interval is measured in clk cycles, and a LOST/ACQUIRE/PRESENT state
// machine tracks whether a usable reference is present.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high reset
//   extClkIn       asynchronous external reference clock
//   refDivider     edge divide ratio (0 and 1 both divide by 1)
//   deglitchCount  extra stable cycles before the filtered level may change
//   timeoutCycles  loss-of-reference timeout in clk cycles (0 = disabled)
//   acquireEdges   strobes needed in ACQUIRE before PRESENT (0 acts as 1)
//   referenceClkEn one-clk strobe per divided reference edge
//   refPresent     high while in PRESENT
//   refLost        one-clk pulse on the PRESENT -> LOST transition
//   refPeriod      last measured strobe-to-strobe interval in clk cycles
// ---------------------------------------------------------------------------
module ref_clk_conditioner #(
  parameter int PERIOD_BITS   = 24,
  parameter int DEGLITCH_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     extClkIn,
  input  logic [7:0]               refDivider,
  input  logic [DEGLITCH_BITS-1:0] deglitchCount,
  input  logic [PERIOD_BITS-1:0]   timeoutCycles,
  input  logic [3:0]               acquireEdges,
  output logic                     referenceClkEn,
  output logic                     refPresent,
  output logic                     refLost,
  output logic [PERIOD_BITS-1:0]   refPeriod
);

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [DEGLITCH_BITS-1:0] STAB_ONE   = 1;
  localparam logic [PERIOD_BITS-1:0]   PERIOD_ONE = 1;
  localparam logic [PERIOD_BITS-1:0]   PERIOD_MAX = '1;

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     filt_q, filt_d;
  logic                     filt_prev_q, filt_prev_d;
  logic [DEGLITCH_BITS-1:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]               div_cnt_q, div_cnt_d;
  logic [PERIOD_BITS-1:0]   period_cnt_q, period_cnt_d;
  logic [PERIOD_BITS-1:0]   ref_period_q, ref_period_d;
  logic [3:0]               good_q, good_d;
  state_t                   state_q, state_d;
  logic                     ref_clk_en_q, ref_clk_en_d;
  logic                     ref_present_q, ref_present_d;
  logic                     ref_lost_q, ref_lost_d;

  logic                     rise;
  logic                     strobe;
  logic                     timeout_hit;
  logic [PERIOD_BITS-1:0]   elapsed;
  logic [3:0]               acq_eff;
  logic [3:0]               good_inc;

  // Datapath: synchroniser, deglitch filter, edge detect, divider and
  // period measurement.
  always_comb begin
    sync1_d      = extClkIn;
    sync2_d      = sync1_q;
    filt_d       = filt_q;
    stab_cnt_d   = '0;
    filt_prev_d  = filt_q;
    rise         = 1'b0;
    strobe       = 1'b0;
    div_cnt_d    = div_cnt_q;
    period_cnt_d = period_cnt_q;
    ref_period_d = ref_period_q;
    elapsed      = period_cnt_q + PERIOD_ONE;
    timeout_hit  = 1'b0;

    // The filtered level only flips once the synchronised input has
    // disagreed with it for deglitchCount+1 cycles in a row; any agreeing
    // cycle throws the partial run away.
    if (sync2_q != filt_q) begin
      if (stab_cnt_q == deglitchCount) begin
        filt_d = ~filt_q;
      end else begin
        stab_cnt_d = stab_cnt_q + STAB_ONE;
      end
    end

    rise = filt_q & ~filt_prev_q;

    // The divider strobes when it is already at zero, so the first rise
    // after reset always produces a strobe. The ratio is only sampled on
    // reload.
    if (rise) begin
      if (div_cnt_q == 8'd0) begin
        strobe    = 1'b1;
        div_cnt_d = (refDivider <= 8'd1) ? 8'd0 : (refDivider - 8'd1);
      end else begin
        div_cnt_d = div_cnt_q - 8'd1;
      end
    end

    // The counter holds (cycles since the last strobe) - 1. Both the period
    // capture and the timeout therefore work on count+1: a strobe P cycles
    // after the previous one reports P, and it masks a timeout of P.
    if (strobe) begin
      period_cnt_d = '0;
    end else if (period_cnt_q != PERIOD_MAX) begin
      period_cnt_d = period_cnt_q + PERIOD_ONE;
    end

    // A saturated count is not a valid period, and measurements taken while
    // LOST span the outage rather than a real reference period.
    if (strobe && (state_q != ST_LOST) && (period_cnt_q != PERIOD_MAX)) begin
      ref_period_d = elapsed;
    end

    timeout_hit = (timeoutCycles != '0) && (elapsed == timeoutCycles) && !strobe;
  end

  // Presence state machine: next state and registered outputs.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    ref_lost_d    = 1'b0;
    ref_clk_en_d  = strobe;
    acq_eff       = (acquireEdges == 4'd0) ? 4'd1 : acquireEdges;
    good_inc      = good_q + 4'd1;

    case (state_q)
      ST_LOST: begin
        if (strobe) begin
          good_d  = 4'd1;
          state_d = (acq_eff == 4'd1) ? ST_PRESENT : ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (timeout_hit) begin
          state_d = ST_LOST;
          good_d  = 4'd0;
        end else if (strobe) begin
          good_d = good_inc;
          if (good_inc >= acq_eff) begin
            state_d = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (timeout_hit) begin
          state_d    = ST_LOST;
          good_d     = 4'd0;
          ref_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOST;
        good_d  = 4'd0;
      end
    endcase

    ref_present_d = (state_d == ST_PRESENT);
  end

  // All state, including the synchroniser, clears on reset so in-flight
  // reference edges are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      filt_q        <= 1'b0;
      filt_prev_q   <= 1'b0;
      stab_cnt_q    <= '0;
      div_cnt_q     <= 8'd0;
      period_cnt_q  <= '0;
      ref_period_q  <= '0;
      good_q        <= 4'd0;
      state_q       <= ST_LOST;
      ref_clk_en_q  <= 1'b0;
      ref_present_q <= 1'b0;
      ref_lost_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_prev_d;
      stab_cnt_q    <= stab_cnt_d;
      div_cnt_q     <= div_cnt_d;
      period_cnt_q  <= period_cnt_d;
      ref_period_q  <= ref_period_d;
      good_q        <= good_d;
      state_q       <= state_d;
      ref_clk_en_q  <= ref_clk_en_d;
      ref_present_q <= ref_present_d;
      ref_lost_q    <= ref_lost_d;
    end
  end

  assign referenceClkEn = ref_clk_en_q;
  assign refPresent     = ref_present_q;
  assign refLost        = ref_lost_q;
  assign refPeriod      = ref_period_q;

endmodule

// File: tb/tb_ref_clk_conditioner.sv
// ---------------------------------------------------------------------------
// tb_ref_clk_conditioner
//
// Directed bench for ref_clk_conditioner. A generator process produces the
// external reference as a programmable high/low pattern aligned to the clk
// falling edge. The main sequence samples the DUT 1 ns after each rising
// edge and compares against hand-computed strobe spacings, latencies and
// state observations.
// ---------------------------------------------------------------------------
module tb_ref_clk_conditioner;

  logic        clk;
  logic        reset;
  logic        extClkIn;
  logic [7:0]  refDivider;
  logic [3:0]  deglitchCount;
  logic [23:0] timeoutCycles;
  logic [3:0]  acquireEdges;
  logic        referenceClkEn;
  logic        refPresent;
  logic        refLost;
  logic [23:0] refPeriod;

  int checks;
  int errors;

  bit ext_on;
  int ext_hi;
  int ext_lo;
  int ext_phase;
  int lost_count;

  ref_clk_conditioner #(
    .PERIOD_BITS  (24),
    .DEGLITCH_BITS(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .extClkIn      (extClkIn),
    .refDivider    (refDivider),
    .deglitchCount (deglitchCount),
    .timeoutCycles (timeoutCycles),
    .acquireEdges  (acquireEdges),
    .referenceClkEn(referenceClkEn),
    .refPresent    (refPresent),
    .refLost       (refLost),
    .refPeriod     (refPeriod)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External reference generator. It restarts at phase 0, driving high
  // first, whenever it is switched on.
  initial begin
    extClkIn  = 1'b0;
    ext_phase = 0;
    forever begin
      @(negedge clk);
      if (!ext_on) begin
        ext_phase = 0;
        extClkIn  = 1'b0;
      end else begin
        extClkIn  = (ext_phase < ext_hi);
        ext_phase = ext_phase + 1;
        if (ext_phase >= ext_hi + ext_lo) ext_phase = 0;
      end
    end
  end

  // Count refLost pulses mid-cycle, away from the sampling point.
  initial begin
    lost_count = 0;
    forever begin
      @(negedge clk);
      if (refLost === 1'b1) lost_count = lost_count + 1;
    end
  end

  // Stop the run if the sequence somehow stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] div, input logic [3:0] dgl,
                               input logic [23:0] tmo, input logic [3:0] acq);
    refDivider    = div;
    deglitchCount = dgl;
    timeoutCycles = tmo;
    acquireEdges  = acq;
  endtask

  task automatic applyReset(input int n);
    ext_on = 1'b0;
    reset  = 1'b1;
    repeat (n) step();
    reset  = 1'b0;
    repeat (3) step();
  endtask

  // Number of cycles until the next visible strobe, or 0 if none arrives
  // within the budget.
  task automatic waitStrobe(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (referenceClkEn === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int base;
    checks        = 0;
    errors        = 0;
    ext_on        = 1'b0;
    ext_hi        = 10;
    ext_lo        = 10;
    reset         = 1'b1;
    applyStimulus(8'd1, 4'd0, 24'd0, 4'd3);

    // Reset state
    applyReset(3);
    checkOutput("reset_en", {31'd0, referenceClkEn}, 32'd0);
    checkOutput("reset_present", {31'd0, refPresent}, 32'd0);
    checkOutput("reset_lost", {31'd0, refLost}, 32'd0);
    checkOutput("reset_period", {8'd0, refPeriod}, 32'd0);

    // Divide-by-1: latency, spacing and acquisition after three strobes
    $display("[TB] divide-by-1 and latency");
    applyStimulus(8'd1, 4'd0, 24'd1000, 4'd3);
    ext_hi = 10; ext_lo = 10; ext_on = 1'b1;
    waitStrobe(40, n);
    checkOutput("d1_latency", n, 32'd4);
    checkOutput("d1_period_first", {8'd0, refPeriod}, 32'd0);
    checkOutput("d1_present_s1", {31'd0, refPresent}, 32'd0);
    waitStrobe(40, n);
    checkOutput("d1_gap2", n, 32'd20);
    checkOutput("d1_period_s2", {8'd0, refPeriod}, 32'd20);
    checkOutput("d1_present_s2", {31'd0, refPresent}, 32'd0);
    waitStrobe(40, n);
    checkOutput("d1_gap3", n, 32'd20);
    checkOutput("d1_present_s3", {31'd0, refPresent}, 32'd1);
    step();
    checkOutput("d1_single_cycle", {31'd0, referenceClkEn}, 32'd0);

    // Divider: 5 then 2, change effective at the following reload
    $display("[TB] divider");
    applyStimulus(8'd5, 4'd0, 24'd0, 4'd1);
    applyReset(2);
    ext_hi = 5; ext_lo = 5; ext_on = 1'b1;
    waitStrobe(40, n);
    checkOutput("div_latency", n, 32'd4);
    waitStrobe(80, n);
    checkOutput("div5_gap", n, 32'd50);
    checkOutput("div5_period", {8'd0, refPeriod}, 32'd50);
    refDivider = 8'd2;
    waitStrobe(80, n);
    checkOutput("div_change_gap", n, 32'd50);
    waitStrobe(80, n);
    checkOutput("div2_gap", n, 32'd20);
    checkOutput("div2_period", {8'd0, refPeriod}, 32'd20);

    // Deglitch: 3-cycle pulses rejected, 4-cycle pulses pass
    $display("[TB] deglitch");
    applyStimulus(8'd1, 4'd3, 24'd0, 4'd1);
    applyReset(2);
    ext_hi = 3; ext_lo = 7; ext_on = 1'b1;
    waitStrobe(60, n);
    checkOutput("dg_short_none", n, 32'd0);
    ext_on = 1'b0;
    repeat (12) step();
    ext_hi = 4; ext_lo = 6; ext_on = 1'b1;
    waitStrobe(40, n);
    checkOutput("dg_latency", n, 32'd7);
    waitStrobe(40, n);
    checkOutput("dg_gap", n, 32'd10);

    // Loss of reference and reacquisition
    $display("[TB] loss of reference");
    applyStimulus(8'd1, 4'd0, 24'd100, 4'd2);
    applyReset(2);
    ext_hi = 10; ext_lo = 10; ext_on = 1'b1;
    waitStrobe(40, n);
    waitStrobe(40, n);
    waitStrobe(40, n);
    checkOutput("loss_pre_present", {31'd0, refPresent}, 32'd1);
    checkOutput("loss_pre_period", {8'd0, refPeriod}, 32'd20);
    ext_on = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (refLost === 1'b1) begin
        n = i;
        break;
      end
    end
    checkOutput("loss_delay", n, 32'd100);
    checkOutput("loss_present_low", {31'd0, refPresent}, 32'd0);
    checkOutput("loss_period_hold", {8'd0, refPeriod}, 32'd20);
    step();
    checkOutput("loss_pulse_once", {31'd0, refLost}, 32'd0);
    ext_hi = 8; ext_lo = 8; ext_on = 1'b1;
    waitStrobe(40, n);
    checkOutput("reacq_latency", n, 32'd4);
    checkOutput("reacq_period_hold", {8'd0, refPeriod}, 32'd20);
    checkOutput("reacq_present_s1", {31'd0, refPresent}, 32'd0);
    waitStrobe(40, n);
    checkOutput("reacq_gap", n, 32'd16);
    checkOutput("reacq_period", {8'd0, refPeriod}, 32'd16);
    checkOutput("reacq_present_s2", {31'd0, refPresent}, 32'd1);

    // Boundary: period 100 against timeouts of 100, 99 and disabled
    $display("[TB] timeout boundary");
    applyStimulus(8'd1, 4'd0, 24'd100, 4'd1);
    applyReset(2);
    ext_hi = 50; ext_lo = 50; ext_on = 1'b1;
    waitStrobe(40, n);
    base = lost_count;
    for (int k = 0; k < 3; k++) begin
      waitStrobe(150, n);
      checkOutput("tmo100_gap", n, 32'd100);
      checkOutput("tmo100_present", {31'd0, refPresent}, 32'd1);
    end
    checkOutput("tmo100_no_loss", lost_count - base, 32'd0);
    checkOutput("tmo100_period", {8'd0, refPeriod}, 32'd100);
    timeoutCycles = 24'd99;
    base = lost_count;
    for (int k = 0; k < 3; k++) begin
      waitStrobe(150, n);
      checkOutput("tmo99_gap", n, 32'd100);
    end
    checkOutput("tmo99_losses", lost_count - base, 32'd3);
    checkOutput("tmo99_period_hold", {8'd0, refPeriod}, 32'd100);
    checkOutput("tmo99_present_after", {31'd0, refPresent}, 32'd1);
    timeoutCycles = 24'd0;
    ext_on = 1'b0;
    base = lost_count;
    repeat (300) step();
    checkOutput("tmo0_present", {31'd0, refPresent}, 32'd1);
    checkOutput("tmo0_no_loss", lost_count - base, 32'd0);

    // Reset mid-run while PRESENT and mid-divide
    $display("[TB] reset mid-run");
    applyStimulus(8'd3, 4'd0, 24'd0, 4'd1);
    applyReset(2);
    ext_hi = 10; ext_lo = 10; ext_on = 1'b1;
    waitStrobe(40, n);
    waitStrobe(80, n);
    checkOutput("mid_div3_gap", n, 32'd60);
    checkOutput("mid_pre_period", {8'd0, refPeriod}, 32'd60);
    repeat (25) step();
    reset  = 1'b1;
    ext_on = 1'b0;
    step();
    reset  = 1'b0;
    checkOutput("mid_reset_en", {31'd0, referenceClkEn}, 32'd0);
    checkOutput("mid_reset_present", {31'd0, refPresent}, 32'd0);
    checkOutput("mid_reset_lost", {31'd0, refLost}, 32'd0);
    checkOutput("mid_reset_period", {8'd0, refPeriod}, 32'd0);
    repeat (3) step();
    ext_on = 1'b1;
    waitStrobe(40, n);
    checkOutput("mid_first_rise_strobe", n, 32'd4);
    checkOutput("mid_first_period", {8'd0, refPeriod}, 32'd0);
    checkOutput("mid_first_present", {31'd0, refPresent}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
